// File: rtl/hack_uart_tx_pkg.sv
// hack_io_pkg: shared constants and state encoding for Hack memory-mapped I/O.
// Used by the hack_uart_tx slice (optional macro: HACK_UART_TX_PARITY_EN).
package hack_io_pkg;

    localparam logic [14:0] TX_ADDR_DEF   = 15'h6001;
    localparam logic [14:0] STAT_ADDR_DEF = 15'h6002;

    localparam int STAT_BUSY = 0;
    localparam int STAT_OVR  = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/hack_uart_tx_if.sv
// hack_uart_tx_if: Hack CPU data-bus view (addressM/outM/writeM, read data).
// master = CPU side, slave = memory-mapped peripheral.
interface hack_uart_tx_if;
    import hack_io_pkg::*;

    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] rdata;

    modport master (
        output addressM,
        output outM,
        output writeM,
        input  rdata
    );

    modport slave (
        input  addressM,
        input  outM,
        input  writeM,
        output rdata
    );

endinterface

// File: rtl/hack_uart_tx_baud_gen.sv
// uart_baud_gen: bit-period counter, pulses o_bit_done on the last cycle.
// i_clear restarts the period so a new frame starts phase-aligned.
module uart_baud_gen
    import hack_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc       = (r_cnt == TC);
    assign o_bit_done = i_en && w_tc;

    // count cycles within a bit period, wrapping at the terminal count
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_tc) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hack_uart_tx.sv
// hack_uart_tx: memory-mapped 8N1 UART transmitter for the Hack data bus.
// Define HACK_UART_TX_PARITY_EN to add an even-parity bit (8E1 frame).
module hack_uart_tx
    import hack_io_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [14:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [14:0] STAT_ADDR    = STAT_ADDR_DEF
) (
    input  logic           clock,
    input  logic           reset,
    hack_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           busy
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_STOP   = STOP;
`ifdef HACK_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif

    logic [2:0]  r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_idx;
    logic        r_txd;
    logic        r_busy;
    logic        r_ovr;
`ifdef HACK_UART_TX_PARITY_EN
    logic        r_par;
`endif

    logic        w_tx_wr;
    logic        w_stat_wr;
    logic        w_accept;
    logic        w_bit_done;
    logic [15:0] w_stat;
    logic        w_unused_hi;

    assign w_tx_wr     = bus.writeM && (bus.addressM == TX_ADDR);
    assign w_stat_wr   = bus.writeM && (bus.addressM == STAT_ADDR);
    assign w_accept    = w_tx_wr && (r_state == S_IDLE);
    assign w_unused_hi = ^bus.outM[15:8];

    assign txd  = r_txd;
    assign busy = r_busy;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clear    (w_accept),
        .i_en       (r_busy),
        .o_bit_done (w_bit_done)
    );

    // frame sequencer: start bit, 8 data bits LSB first, [parity], stop bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
`ifdef HACK_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= bus.outM[7:0];
                        r_idx   <= '0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
`ifdef HACK_UART_TX_PARITY_EN
                        r_par   <= even_parity(bus.outM[7:0]);
`endif
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_txd   <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        if (r_idx == 3'd7) begin
`ifdef HACK_UART_TX_PARITY_EN
                            r_txd   <= r_par;
                            r_state <= S_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end
                end
`ifdef HACK_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_done) begin
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // sticky overrun: a TX write while busy sets it, a status write clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovr <= 1'b0;
        end else if (w_tx_wr && r_busy) begin
            r_ovr <= 1'b1;
        end else if (w_stat_wr) begin
            r_ovr <= 1'b0;
        end
    end

    // status word for the inM mux, decoded from the address alone
    always_comb begin
        w_stat            = '0;
        w_stat[STAT_BUSY] = r_busy;
        w_stat[STAT_OVR]  = r_ovr;
        bus.rdata         = (bus.addressM == STAT_ADDR) ? w_stat : 16'h0000;
    end

endmodule
